// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) answering the hazard unit's div_start/div_ready handshake.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero one cycle after the start is sampled.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic               div_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               signed_q, signed_d;
    logic               sign1_q, sign1_d;
    logic               sign2_q, sign2_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;      // |dividend|, shifted out MSB-first while quotient bits shift in
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   raw_q, raw_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [WIDTH-1:0]   rem_next, quo_next, quo_fix, rem_fix;

    // The full remainder is shifted (not just its low bits) so divisors above 2^(WIDTH-1) stay exact.
    always_comb begin
        diff     = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dsr_q};
        qbit     = ~diff[WIDTH];
        rem_next = qbit ? diff[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        quo_next = {dvd_q[WIDTH-2:0], qbit};
        quo_fix  = (signed_q && (sign1_q ^ sign2_q)) ? -quo_next : quo_next;
        rem_fix  = (signed_q && sign1_q) ? -rem_next : rem_next;
        if (dsr_q == '0) begin
            quo_fix = '1;
            rem_fix = raw_q;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        raw_d     = raw_q;
        result_d  = result_q;
        div_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (div_start && !annul) begin
                    signed_d = div_signed;
                    sign1_d  = opdata1[WIDTH-1];
                    sign2_d  = opdata2[WIDTH-1];
                    dvd_d    = (div_signed && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
                    dsr_d    = (div_signed && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
                    raw_d    = opdata1;
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2 == '0) begin
                        state_d  = DONE;
                        result_d = {opdata1, {WIDTH{1'b1}}};
                    end
`else
`endif
                end
            end
            BUSY: begin
                if (annul || !div_start) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_next;
                    dvd_d = quo_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = DONE;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            DONE: begin
                div_ready = !annul;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            raw_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            signed_q <= signed_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            raw_q    <= raw_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected HI/LO results are queued at stimulus time and popped on div_ready.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_start;
    logic        div_signed;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        div_ready;
    logic [63:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_res;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .div_start (div_start),
        .div_signed(div_signed),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .annul     (annul),
        .div_ready (div_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Counts negedges after the sampling edge until div_ready, bounded by budget.
    task automatic wait_ready(output int cyc, input int budget);
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!div_ready && cyc < budget);
    endtask

    task automatic count_pulses(output int pulses, input int ncyc);
        pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (div_ready) pulses++;
        end
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_lat, input string tag);
        int cyc;
        logic [63:0] e;
        @(negedge clk);
        div_signed = sgn;
        opdata1    = a;
        opdata2    = b;
        div_start  = 1'b1;
        exp_q.push_back(exp_res);
        wait_ready(cyc, 40);
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        e = exp_q.pop_front();
        chk({tag, "_res"}, result, e);
        last_res  = e;
        div_start = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(div_ready), 64'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        logic [63:0] e;

        resetn = 1'b0; div_start = 1'b0; div_signed = 1'b0;
        opdata1 = '0; opdata2 = '0; annul = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(div_ready), 64'd0);
        chk("rst_result", result, 64'd0);
        resetn = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "divu_100_7");
        run_div(1'b1, -32'sd7, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        run_div(1'b1, 32'd7, -32'sd2, {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2");
        run_div(1'b1, -32'sd7, -32'sd2, {32'hFFFF_FFFF, 32'd3}, 33, "div_m7_m2");
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, "div_ovf");
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, "divu_max_1");
        run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'd1, 32'd1}, 33, "divu_big_dsr");
        run_div(1'b1, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, ZERO_LAT, "div_by_zero");

        // annul at BUSY step 10
        @(negedge clk);
        div_signed = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd7; div_start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1 chk("annul10_ready", 64'(div_ready), 64'd0);
        @(negedge clk);
        annul = 1'b0; div_start = 1'b0;
        count_pulses(pulses, 40);
        chk("annul10_no_pulse", 64'(pulses), 64'd0);
        chk("annul10_result_kept", result, last_res);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "divu_9_3");

        // annul coincident with the last BUSY step
        @(negedge clk);
        opdata1 = 32'd77; opdata2 = 32'd5; div_start = 1'b1;
        @(posedge clk);
        repeat (31) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; div_start = 1'b0;
        chk("annul_last_ready", 64'(div_ready), 64'd0);
        count_pulses(pulses, 40);
        chk("annul_last_no_pulse", 64'(pulses), 64'd0);
        chk("annul_last_result_kept", result, last_res);

        // div_start dropped mid-BUSY
        @(negedge clk);
        opdata1 = 32'd88; opdata2 = 32'd3; div_start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        div_start = 1'b0;
        count_pulses(pulses, 40);
        chk("drop_no_pulse", 64'(pulses), 64'd0);

        // back-to-back: start held, second operands presented in the ready cycle
        @(negedge clk);
        div_signed = 1'b0; opdata1 = 32'd50; opdata2 = 32'd5; div_start = 1'b1;
        exp_q.push_back({32'd0, 32'd10});
        wait_ready(cyc, 40);
        chk("b2b1_lat", 64'(cyc), 64'd33);
        e = exp_q.pop_front();
        chk("b2b1_res", result, e);
        opdata1 = 32'd51;
        exp_q.push_back({32'd1, 32'd10});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!div_ready && cyc < 50);
        chk("b2b_gap", 64'(cyc), 64'd34);
        e = exp_q.pop_front();
        chk("b2b2_res", result, e);
        div_start = 1'b0;
        @(negedge clk);
        chk("b2b2_pulse", 64'(div_ready), 64'd0);

        // reset asserted mid-BUSY
        @(negedge clk);
        opdata1 = 32'd500; opdata2 = 32'd4; div_start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid_ready", 64'(div_ready), 64'd0);
        chk("rst_mid_result", result, 64'd0);
        div_start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        count_pulses(pulses, 40);
        chk("rst_mid_no_pulse", 64'(pulses), 64'd0);
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, "post_rst_divu");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
